df_deadlock_detector: RTL and testbench

// Synthesizable dataflow deadlock detector feeding the simulation-side dataflow monitors.

---
 rtl/df_deadlock_detector_if.sv | 28 ++
 rtl/df_deadlock_detector.sv | 95 +++++++++
 tb/tb_df_deadlock_detector.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/df_deadlock_detector_if.sv
// Signal bundle between the observed dataflow design and the deadlock detector.
// The detector uses the slave modport; the stimulus side uses the master modport.
interface df_deadlock_detector_if #(
    parameter int unsigned NUM_PROC = 3,
    parameter int unsigned NUM_CHAN = 3,
    parameter int unsigned CNT_W    = 16
);
    logic                finish;
    logic [NUM_PROC-1:0] proc_active;
    logic [NUM_PROC-1:0] proc_blocked;
    logic [NUM_CHAN-1:0] chan_rd_en;
    logic [NUM_CHAN-1:0] chan_wr_en;
    logic                find_df_deadlock;
    logic [NUM_PROC-1:0] deadlock_mask;
    logic [1:0]          det_state;
    logic [CNT_W-1:0]    stall_run;
    logic [CNT_W-1:0]    total_stall;

    modport master (
        output finish, proc_active, proc_blocked, chan_rd_en, chan_wr_en,
        input  find_df_deadlock, deadlock_mask, det_state, stall_run, total_stall
    );

    modport slave (
        input  finish, proc_active, proc_blocked, chan_rd_en, chan_wr_en,
        output find_df_deadlock, deadlock_mask, det_state, stall_run, total_stall
    );
endinterface

// File: rtl/df_deadlock_detector.sv
// Dataflow deadlock detector: flags when every active process stays blocked with no FIFO
// traffic for TIMEOUT consecutive cycles. The flag is sticky until reset.
module df_deadlock_detector #(
    parameter int unsigned NUM_PROC = 3,
    parameter int unsigned NUM_CHAN = 3,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned CNT_W    = 16
) (
    input logic                   clock,
    input logic                   reset,
    df_deadlock_detector_if.slave dif
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWatch    = 2'd1,
        StDeadlock = 2'd2,
        StDone     = 2'd3
    } det_state_e;

    localparam logic [CNT_W-1:0] RunLast = CNT_W'(TIMEOUT - 1);

    det_state_e          state_q, state_d;
    logic                flag_q, flag_d;
    logic [NUM_PROC-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]    run_q, run_d;
    logic [CNT_W-1:0]    total_q, total_d;
    logic                stuck;

    // Inactive processes never veto; any strobe on any channel does.
    assign stuck = (|dif.proc_active)
                && ((dif.proc_active & ~dif.proc_blocked) == '0)
                && !(|dif.chan_rd_en)
                && !(|dif.chan_wr_en);

    always_comb begin
        state_d = state_q;
        flag_d  = flag_q;
        mask_d  = mask_q;
        run_d   = run_q;
        total_d = total_q;
        case (state_q)
            StIdle: begin
                if (dif.finish) begin
                    state_d = StDone;
                end else if (|dif.proc_active) begin
                    state_d = StWatch;
                end
            end
            StWatch: begin
                // finish wins over a same-cycle confirmation; counters freeze with it
                if (dif.finish) begin
                    state_d = StDone;
                end else if (stuck) begin
                    if (total_q != '1) begin
                        total_d = total_q + 1'b1;
                    end
                    if (run_q >= RunLast) begin
                        state_d = StDeadlock;
                        flag_d  = 1'b1;
                        mask_d  = dif.proc_blocked & dif.proc_active;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end else begin
                    run_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            flag_q  <= 1'b0;
            mask_q  <= '0;
            run_q   <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            mask_q  <= mask_d;
            run_q   <= run_d;
            total_q <= total_d;
        end
    end

    assign dif.find_df_deadlock = flag_q;
    assign dif.deadlock_mask    = mask_q;
    assign dif.det_state        = state_q;
    assign dif.stall_run        = run_q;
    assign dif.total_stall      = total_q;

endmodule

// File: tb/tb_df_deadlock_detector.sv
// Directed bench for df_deadlock_detector: reset, detection timing, traffic veto,
// partial blocking, finish race and asynchronous reset out of DEADLOCK.
module tb_df_deadlock_detector;

    localparam int unsigned NP = 3;
    localparam int unsigned NC = 3;
    localparam int unsigned TO = 64;
    localparam int unsigned CW = 16;

    logic clock;
    logic reset;
    int   n_total;
    int   n_pass;

    df_deadlock_detector_if #(.NUM_PROC(NP), .NUM_CHAN(NC), .CNT_W(CW)) dif ();

    df_deadlock_detector #(
        .NUM_PROC(NP),
        .NUM_CHAN(NC),
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .dif  (dif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Returns 1 ns after a rising edge, away from the active edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_in(input logic [NP-1:0] act, input logic [NP-1:0] blk);
        dif.proc_active  = act;
        dif.proc_blocked = blk;
        dif.chan_rd_en   = '0;
        dif.chan_wr_en   = '0;
        dif.finish       = 1'b0;
    endtask

    task automatic do_reset();
        set_in('0, '0);
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    // Enters WATCH with a non-stuck pattern so counting starts on the next edge.
    task automatic enter_watch(input string tag);
        set_in(3'b111, 3'b000);
        tick(1);
        check({tag, "_watch"}, 32'(dif.det_state), 32'd1);
    endtask

    task automatic expect_deadlock(input string tag, input logic [NP-1:0] mask);
        tick(TO - 1);
        check({tag, "_flag_pre"}, 32'(dif.find_df_deadlock), 32'd0);
        check({tag, "_run_pre"}, 32'(dif.stall_run), TO - 1);
        tick(1);
        check({tag, "_flag"}, 32'(dif.find_df_deadlock), 32'd1);
        check({tag, "_state"}, 32'(dif.det_state), 32'd2);
        check({tag, "_mask"}, 32'(dif.deadlock_mask), 32'(mask));
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset   = 1'b0;
        set_in('0, '0);

        // T1: random inputs under reset, then idle after release
        for (int i = 0; i < 6; i++) begin
            dif.proc_active  = NP'($urandom);
            dif.proc_blocked = NP'($urandom);
            dif.chan_rd_en   = NC'($urandom);
            dif.chan_wr_en   = NC'($urandom);
            dif.finish       = 1'($urandom);
            tick(1);
            check("t1_state", 32'(dif.det_state), 32'd0);
        end
        check("t1_flag", 32'(dif.find_df_deadlock), 32'd0);
        check("t1_mask", 32'(dif.deadlock_mask), 32'd0);
        check("t1_run", 32'(dif.stall_run), 32'd0);
        check("t1_total", 32'(dif.total_stall), 32'd0);
        set_in('0, 3'b111);
        reset = 1'b1;
        tick(5);
        check("t1_idle", 32'(dif.det_state), 32'd0);
        check("t1_idle_total", 32'(dif.total_stall), 32'd0);

        // T2: everything blocked, no traffic
        do_reset();
        enter_watch("t2");
        set_in(3'b111, 3'b111);
        expect_deadlock("t2", 3'b111);
        check("t2_total", 32'(dif.total_stall), 32'd64);
        dif.finish = 1'b1;
        tick(10);
        check("t2_frozen_state", 32'(dif.det_state), 32'd2);
        check("t2_frozen_total", 32'(dif.total_stall), 32'd64);
        dif.finish = 1'b0;

        // T6: async reset between edges clears immediately, then redetect
        #2;
        reset = 1'b0;
        #1;
        check("t6_flag", 32'(dif.find_df_deadlock), 32'd0);
        check("t6_state", 32'(dif.det_state), 32'd0);
        check("t6_mask", 32'(dif.deadlock_mask), 32'd0);
        check("t6_total", 32'(dif.total_stall), 32'd0);
        #1;
        reset = 1'b1;
        tick(1);
        check("t6_watch", 32'(dif.det_state), 32'd1);
        check("t6_total0", 32'(dif.total_stall), 32'd0);
        expect_deadlock("t6", 3'b111);

        // T3: single write strobe after 40 stuck cycles restarts the run
        do_reset();
        enter_watch("t3");
        set_in(3'b111, 3'b111);
        tick(40);
        check("t3_run40", 32'(dif.stall_run), 32'd40);
        dif.chan_wr_en = 3'b010;
        tick(1);
        check("t3_run_clr", 32'(dif.stall_run), 32'd0);
        check("t3_total40", 32'(dif.total_stall), 32'd40);
        dif.chan_wr_en = '0;
        expect_deadlock("t3", 3'b111);
        check("t3_total", 32'(dif.total_stall), 32'd104);

        // T4: one unblocked active process vetoes, then it goes inactive
        do_reset();
        enter_watch("t4");
        set_in(3'b111, 3'b101);
        tick(500);
        check("t4_flag", 32'(dif.find_df_deadlock), 32'd0);
        check("t4_run", 32'(dif.stall_run), 32'd0);
        check("t4_state", 32'(dif.det_state), 32'd1);
        set_in(3'b101, 3'b101);
        expect_deadlock("t4", 3'b101);

        // T5: finish on the confirming cycle wins
        do_reset();
        enter_watch("t5");
        set_in(3'b111, 3'b111);
        tick(TO - 1);
        check("t5_run", 32'(dif.stall_run), TO - 1);
        dif.finish = 1'b1;
        tick(1);
        check("t5_state", 32'(dif.det_state), 32'd3);
        check("t5_flag", 32'(dif.find_df_deadlock), 32'd0);
        dif.finish = 1'b0;
        tick(200);
        check("t5_state_hold", 32'(dif.det_state), 32'd3);
        check("t5_flag_hold", 32'(dif.find_df_deadlock), 32'd0);
        check("t5_mask_hold", 32'(dif.deadlock_mask), 32'd0);

        // DONE straight from IDLE
        do_reset();
        dif.finish = 1'b1;
        tick(1);
        check("idle_done", 32'(dif.det_state), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
